// File: rtl/bcd_mod_counter_pkg.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter_pkg
// Shared types, constants and helpers for the two-digit BCD counter stages
// (hour/minute/second) and for the 24h->12h display conversion.
// ---------------------------------------------------------------------------
package bcd_mod_counter_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    localparam bcd_t       BCD_MAX  = 4'd9;
    localparam logic [6:0] H12_NOON = 7'd12;

    // Binary value of a two-digit BCD number. Only meaningful when both
    // digits are <= 9; callers qualify the result with a digit check.
    function automatic logic [6:0] bcd_to_bin(input bcd_t h, input bcd_t l);
        return ({3'b000, h} * 7'd10) + {3'b000, l};
    endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter_if
// Control and display bundle of one counter stage.
//   master : drives EN, DN, LOAD, LD_H, LD_L, MODE12; reads the display
//   slave  : the counter itself
// Signals:
//   EN      count enable          DN    direction (0 up, 1 down)
//   LOAD    time-set load strobe  LD_H  tens digit to load, LD_L units digit
//   MODE12  12-hour display       cntH/cntL displayed digits
//   PM      afternoon flag        CO/BO carry / borrow pulse
//   ERR     sticky rejected-load flag
// ---------------------------------------------------------------------------
interface bcd_mod_counter_if;
    import bcd_mod_counter_pkg::*;

    logic EN;
    logic DN;
    logic LOAD;
    bcd_t LD_H;
    bcd_t LD_L;
    logic MODE12;
    bcd_t cntH;
    bcd_t cntL;
    logic PM;
    logic CO;
    logic BO;
    logic ERR;

    modport master (
        output EN, DN, LOAD, LD_H, LD_L, MODE12,
        input  cntH, cntL, PM, CO, BO, ERR
    );

    modport slave (
        input  EN, DN, LOAD, LD_H, LD_L, MODE12,
        output cntH, cntL, PM, CO, BO, ERR
    );

endinterface

// File: rtl/bcd_mod_counter_h24_to_h12.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter_h24_to_h12
// Combinational 24h -> 12h conversion on BCD digits.
//   0 -> 12, 1..12 unchanged, 13..23 -> value-12; pm_o high for 12..23.
// Ports:
//   h24_h_i/h24_l_i : legal 24h hour (00..23) in BCD
//   h12_h_o/h12_l_o : 12h display digits
//   pm_o            : afternoon flag
// ---------------------------------------------------------------------------
module bcd_mod_counter_h24_to_h12
    import bcd_mod_counter_pkg::*;
(
    input  bcd_t h24_h_i,
    input  bcd_t h24_l_i,
    output bcd_t h12_h_o,
    output bcd_t h12_l_o,
    output logic pm_o
);

    always_comb begin
        h12_h_o = h24_h_i;
        h12_l_o = h24_l_i;
        case (h24_h_i)
            4'd0: begin
                if (h24_l_i == 4'd0) begin
                    h12_h_o = 4'd1;
                    h12_l_o = 4'd2;
                end
            end
            4'd1: begin
                // 13..19 -> 01..07
                if (h24_l_i > 4'd2) begin
                    h12_h_o = 4'd0;
                    h12_l_o = h24_l_i - 4'd2;
                end
            end
            4'd2: begin
                // 20,21 -> 08,09 ; 22,23 -> 10,11
                if (h24_l_i <= 4'd1) begin
                    h12_h_o = 4'd0;
                    h12_l_o = h24_l_i + 4'd8;
                end else begin
                    h12_h_o = 4'd1;
                    h12_l_o = h24_l_i - 4'd2;
                end
            end
            default: ;
        endcase
        pm_o = (bcd_to_bin(h24_h_i, h24_l_i) >= H12_NOON);
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
// Two-digit BCD modulo-MOD counter stage with up/down count, validated
// time-set load, optional 12-hour display and carry/borrow pulses.
// Parameters:
//   the modulus parameter sets the count range 0..MOD-1 (legal 2..99);
//   the 12-hour enable parameter adds the 12h display when MOD is 24.
// Ports:
//   CP  : counting clock, rising edge
//   CR  : asynchronous active-high clear
//   bus : control inputs and registered display/status outputs
// ---------------------------------------------------------------------------
module bcd_mod_counter
    import bcd_mod_counter_pkg::*;
#(
    parameter int MOD    = 24,
    parameter int H12_EN = 1
) (
    input  logic             CP,
    input  logic             CR,
    bcd_mod_counter_if.slave bus
);

    localparam logic [6:0] MOD_B  = 7'(MOD);
    localparam logic [6:0] LAST_B = 7'(MOD - 1);
    localparam bcd_t       LAST_H = 4'((MOD - 1) / 10);
    localparam bcd_t       LAST_L = 4'((MOD - 1) % 10);
    localparam bit         H12_OK = (H12_EN != 0) && (MOD == 24);

    bcd_t       s_h_q, s_l_q, s_h_d, s_l_d;
    bcd_t       disp_h_q, disp_l_q, disp_h_d, disp_l_d;
    logic       pm_q, pm_d;
    logic       co_q, co_d;
    logic       bo_q, bo_d;
    logic       err_q, err_d;
    logic       rst_disp_q;
    logic [6:0] cur_bin, ld_bin;
    logic       cur_bad, ld_ok, use12;
    bcd_t       cv_h, cv_l;
    logic       cv_pm;

    assign use12 = H12_OK && bus.MODE12;

    // Next-state: LOAD > illegal-state recovery > count > hold.
    always_comb begin
        cur_bin = bcd_to_bin(s_h_q, s_l_q);
        ld_bin  = bcd_to_bin(bus.LD_H, bus.LD_L);
        cur_bad = (s_h_q > BCD_MAX) || (s_l_q > BCD_MAX) || (cur_bin >= MOD_B);
        ld_ok   = (bus.LD_H <= BCD_MAX) && (bus.LD_L <= BCD_MAX) && (ld_bin < MOD_B);

        s_h_d = s_h_q;
        s_l_d = s_l_q;
        co_d  = 1'b0;
        bo_d  = 1'b0;
        err_d = err_q;

        if (bus.LOAD) begin
            if (ld_ok) begin
                s_h_d = bus.LD_H;
                s_l_d = bus.LD_L;
                err_d = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end else if (cur_bad) begin
            s_h_d = 4'd0;
            s_l_d = 4'd0;
        end else if (bus.EN) begin
            if (!bus.DN) begin
                if (cur_bin == LAST_B) begin
                    s_h_d = 4'd0;
                    s_l_d = 4'd0;
                    co_d  = 1'b1;
                end else if (s_l_q == BCD_MAX) begin
                    s_l_d = 4'd0;
                    s_h_d = s_h_q + 4'd1;
                end else begin
                    s_l_d = s_l_q + 4'd1;
                end
            end else begin
                if (cur_bin == 7'd0) begin
                    s_h_d = LAST_H;
                    s_l_d = LAST_L;
                    bo_d  = 1'b1;
                end else if (s_l_q == 4'd0) begin
                    s_l_d = BCD_MAX;
                    s_h_d = s_h_q - 4'd1;
                end else begin
                    s_l_d = s_l_q - 4'd1;
                end
            end
        end
    end

    // Display is derived from the next state so it updates on the same edge.
    bcd_mod_counter_h24_to_h12 u_h12 (
        .h24_h_i (s_h_d),
        .h24_l_i (s_l_d),
        .h12_h_o (cv_h),
        .h12_l_o (cv_l),
        .pm_o    (cv_pm)
    );

    always_comb begin
        disp_h_d = use12 ? cv_h : s_h_d;
        disp_l_d = use12 ? cv_l : s_l_d;
        pm_d     = use12 & cv_pm;
    end

    always_ff @(posedge CP or posedge CR) begin
        if (CR) begin
            s_h_q      <= 4'd0;
            s_l_q      <= 4'd0;
            disp_h_q   <= 4'd0;
            disp_l_q   <= 4'd0;
            pm_q       <= 1'b0;
            co_q       <= 1'b0;
            bo_q       <= 1'b0;
            err_q      <= 1'b0;
            rst_disp_q <= 1'b1;
        end else begin
            s_h_q      <= s_h_d;
            s_l_q      <= s_l_d;
            disp_h_q   <= disp_h_d;
            disp_l_q   <= disp_l_d;
            pm_q       <= pm_d;
            co_q       <= co_d;
            bo_q       <= bo_d;
            err_q      <= err_d;
            rst_disp_q <= 1'b0;
        end
    end

    // From clear until the first edge the state is 00, whose display depends
    // on the format: midnight shows as 12 in 12h mode. The reset value of a
    // flop cannot depend on MODE12, so a reset-marker flop selects it here.
    assign bus.cntH = rst_disp_q ? (use12 ? 4'd1 : 4'd0) : disp_h_q;
    assign bus.cntL = rst_disp_q ? (use12 ? 4'd2 : 4'd0) : disp_l_q;
    assign bus.PM   = pm_q;
    assign bus.CO   = co_q;
    assign bus.BO   = bo_q;
    assign bus.ERR  = err_q;

endmodule
